frq_divider_multi: RTL and testbench

//  Parametrised N-channel frequency divider. A shared divisor ROM is indexed by a per-channel select code.

---
 rtl/frq_div_pkg.sv | 26 ++
 rtl/frq_div_channel.sv | 70 +++++++
 rtl/frq_divider_multi.sv | 39 +++
 tb/tb_frq_divider_multi.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/frq_div_pkg.sv
// Shared definitions for the multi-channel frequency divider: default widths,
// mode encoding and the divisor ROM contents.
package frq_div_pkg;

  localparam int N_CH_DEF  = 2;
  localparam int SEL_W_DEF = 5;
  localparam int CNT_W_DEF = 16;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  // 0 stops the channel; codes above 27 saturate at the largest 16-bit divisor.
  function automatic logic [15:0] rom_div(input int unsigned k);
    logic [15:0] d;
    if (k == 0)
      d = 16'd0;
    else if (k < 16)
      d = 16'(k);
    else if (k < 28)
      d = 16'd16 << (k - 16);
    else
      d = 16'hFFFF;
    return d;
  endfunction

endpackage

// File: rtl/frq_div_channel.sv
// One divider channel: period counter, active/pending settings and the output flop.
// New settings wait for a period boundary (or an idle channel) before taking over.
module frq_div_channel
  import frq_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] div_ld,
  input  logic             mode_ld,
  input  logic             sel_load,
  input  logic             en,
  output logic             clk_out,
  output logic             pending
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] div_pend;
  logic             mode_act;
  logic             mode_pend;
  logic             idle;
  logic             boundary;
  logic             apply;

  assign idle     = !en || (div_act == '0);
  assign boundary = !idle && (cnt == div_act - CNT_W'(1));
  assign apply    = pending && (boundary || idle);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      div_act   <= '0;
      div_pend  <= '0;
      mode_act  <= MODE_TOGGLE;
      mode_pend <= MODE_TOGGLE;
      pending   <= 1'b0;
      clk_out   <= 1'b0;
    end else begin
      if (idle || boundary)
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);

      if (sel_load) begin
        div_pend  <= div_ld;
        mode_pend <= mode_ld;
      end

      if (apply) begin
        div_act  <= div_pend;
        mode_act <= mode_pend;
      end

      // A load on the apply edge stays queued behind the value being applied.
      pending <= sel_load | (pending & ~apply);

      if (idle)
        clk_out <= 1'b0;
      else if (apply && ((mode_pend != mode_act) || (div_pend == '0)))
        clk_out <= 1'b0;
      else if (boundary)
        clk_out <= (mode_act == MODE_PULSE) ? 1'b1 : ~clk_out;
      else if (mode_act == MODE_PULSE)
        clk_out <= 1'b0;
    end
  end

endmodule

// File: rtl/frq_divider_multi.sv
// N-channel frequency divider: slices the per-channel buses, looks up each
// channel's divisor in the shared ROM and drives one divider channel per lane.
module frq_divider_multi
  import frq_div_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_CH*SEL_W-1:0]   F_select,
  input  logic [N_CH-1:0]         mode,
  input  logic [N_CH-1:0]         sel_load,
  input  logic [N_CH-1:0]         en,
  output logic [N_CH-1:0]         clk_out,
  output logic [N_CH-1:0]         pending
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] div_sel;

    assign div_sel = CNT_W'(rom_div(int'(F_select[i*SEL_W +: SEL_W])));

    frq_div_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .div_ld   (div_sel),
      .mode_ld  (mode[i]),
      .sel_load (sel_load[i]),
      .en       (en[i]),
      .clk_out  (clk_out[i]),
      .pending  (pending[i])
    );
  end

endmodule

// File: tb/tb_frq_divider_multi.sv
// Directed bench for frq_divider_multi: reset behaviour, toggle/pulse waveforms,
// boundary-aligned setting changes and channel independence.
module tb_frq_divider_multi;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] F_select;
  logic [1:0] mode;
  logic [1:0] sel_load;
  logic [1:0] en;
  logic [1:0] clk_out;
  logic [1:0] pending;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  frq_divider_multi dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .F_select (F_select),
    .mode     (mode),
    .sel_load (sel_load),
    .en       (en),
    .clk_out  (clk_out),
    .pending  (pending)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int ch, input int sel, input logic md);
    F_select[ch*5 +: 5] = 5'(sel);
    mode[ch]            = md;
    sel_load[ch]        = 1'b1;
    tick();
    sel_load[ch]        = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    F_select = '0;
    mode     = '0;
    sel_load = '0;
    en       = '0;

    repeat (3) tick();
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    reset_n = 1'b1;
    repeat (3) tick();
    chk("idle_clk_out", 32'(clk_out), 32'd0);
    chk("idle_pending", 32'(pending), 32'd0);

    // ch0 toggle, D=4: first rise 5 edges after the load, period 8
    en[0] = 1'b1;
    load(0, 4, 1'b0);
    chk("t2_pend_load", 32'(pending[0]), 32'd1);
    chk("t2_clk_load", 32'(clk_out[0]), 32'd0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("t2_clk", 32'(clk_out[0]), 32'(((k - 1) / 4) % 2));
      if (k == 1) chk("t2_pend_apply", 32'(pending[0]), 32'd0);
    end

    // ch1 pulse, D=3, then D=1 (constant high)
    en[1] = 1'b1;
    load(1, 3, 1'b1);
    chk("t3_pend_load", 32'(pending[1]), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("t3_pulse", 32'(clk_out[1]), 32'((k >= 4) && ((k - 4) % 3 == 0)));
    end
    load(1, 1, 1'b1);
    chk("t3_d1_pend", 32'(pending[1]), 32'd1);
    chk("t3_d1_clk_load", 32'(clk_out[1]), 32'd1);
    tick();
    chk("t3_d1_clk_gap", 32'(clk_out[1]), 32'd0);
    tick();
    tick();
    chk("t3_d1_pend_apply", 32'(pending[1]), 32'd0);
    for (int k = 0; k < 8; k++) begin
      chk("t3_d1_const", 32'(clk_out[1]), 32'd1);
      tick();
    end

    // ch0 at D=16, load D=2 while cnt=5: waits 11 cycles, no runt
    en[0] = 1'b0;
    tick();
    chk("t4_idle_clk", 32'(clk_out[0]), 32'd0);
    load(0, 16, 1'b0);
    tick();
    chk("t4_apply_pend", 32'(pending[0]), 32'd0);
    en[0] = 1'b1;
    repeat (4) tick();
    load(0, 2, 1'b0);
    for (int i = 0; i < 11; i++) begin
      if (i > 0) tick();
      chk("t4_pend_wait", 32'(pending[0]), 32'd1);
      chk("t4_clk_wait", 32'(clk_out[0]), 32'd0);
    end
    tick();
    chk("t4_pend_bnd", 32'(pending[0]), 32'd0);
    chk("t4_clk_bnd", 32'(clk_out[0]), 32'd1);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("t4_clk_d2", 32'(clk_out[0]), 32'((k / 2) % 2 == 0));
    end

    // load D=5 on the boundary while D=3 is pending, then stop with D=0
    tick();
    load(0, 3, 1'b0);
    chk("t5_pend3", 32'(pending[0]), 32'd1);
    load(0, 5, 1'b0);
    chk("t5_pend5_bnd", 32'(pending[0]), 32'd1);
    chk("t5_clk_bnd", 32'(clk_out[0]), 32'd0);
    tick();
    tick();
    chk("t5_pend_mid", 32'(pending[0]), 32'd1);
    chk("t5_clk_mid", 32'(clk_out[0]), 32'd0);
    tick();
    chk("t5_pend_apply5", 32'(pending[0]), 32'd0);
    chk("t5_clk_apply5", 32'(clk_out[0]), 32'd1);
    for (int k = 14; k <= 23; k++) begin
      tick();
      chk("t5_clk_d5", 32'(clk_out[0]), 32'(((k - 13) / 5) % 2 == 0));
    end
    load(0, 0, 1'b0);
    chk("t5_stop_pend", 32'(pending[0]), 32'd1);
    chk("t5_stop_clk", 32'(clk_out[0]), 32'd1);
    repeat (3) tick();
    chk("t5_stop_pend_wait", 32'(pending[0]), 32'd1);
    chk("t5_stop_clk_wait", 32'(clk_out[0]), 32'd1);
    tick();
    chk("t5_stop_pend_bnd", 32'(pending[0]), 32'd0);
    chk("t5_stop_clk_bnd", 32'(clk_out[0]), 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t5_stopped", 32'(clk_out[0]), 32'd0);
    end

    // ch0 toggle D=3 while ch1 is churned
    en[0] = 1'b0;
    tick();
    load(0, 3, 1'b0);
    tick();
    en[0] = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      en[1]          = ((j % 7) < 4);
      mode[1]        = ((j / 5) % 2) != 0;
      sel_load[1]    = (j % 6 == 0);
      F_select[9:5]  = 5'(j);
      tick();
      chk("t6_ch0", 32'(clk_out[0]), 32'((j / 3) % 2));
    end
    sel_load[1] = 1'b0;

    // asynchronous reset at a random phase
    load(1, 7, 1'b0);
    chk("t1_pend_before", 32'(pending[1]), 32'd1);
    #($urandom_range(1, 7));
    reset_n = 1'b0;
    #1;
    chk("t1_async_clk", 32'(clk_out), 32'd0);
    chk("t1_async_pend", 32'(pending), 32'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t1_post_clk", 32'(clk_out), 32'd0);
      chk("t1_post_pend", 32'(pending), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
